// File: rtl/hex_scan_driver_pkg.sv
// hex_scan_pkg: shared constants, phase type and width helper for the hex scan driver
package hex_scan_pkg;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   typedef enum logic {BLANK, SHOW} phase_t;
   function automatic int width_of(int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/hex_scan_driver_if.sv
// hex_scan_driver_if: processor hex exports in, multiplexed display pins out
//   hex_in     : 8*DIGITS active-low digit patterns, digit k at [8k+7:8k]
//   disp_en    : 1 = display on, 0 = forced blank
//   bright     : 4-bit brightness (only with HEX_SCAN_DIM_EN)
//   seg        : shared active-low segment bus
//   dig        : active-low one-cold digit enables
//   frame_tick : one-cycle pulse at each frame start
interface hex_scan_driver_if #(parameter int DIGITS = 4);
   logic [8*DIGITS-1:0] hex_in;
   logic                disp_en;
`ifdef HEX_SCAN_DIM_EN
   logic [3:0]          bright;
`endif
   logic [7:0]          seg;
   logic [DIGITS-1:0]   dig;
   logic                frame_tick;
`ifdef HEX_SCAN_DIM_EN
   modport master (output hex_in, disp_en, bright, input seg, dig, frame_tick);
   modport slave (input hex_in, disp_en, bright, output seg, dig, frame_tick);
`else
   modport master (output hex_in, disp_en, input seg, dig, frame_tick);
   modport slave (input hex_in, disp_en, output seg, dig, frame_tick);
`endif
endinterface

// File: rtl/hex_scan_driver_timebase.sv
// hex_scan_timebase: slot counter, digit index, phase and frame_tick generation
//   clk, rst     : clock, asynchronous active-high reset
//   idx_d        : digit index for the cycle starting at the next edge
//   phase_d      : BLANK/SHOW phase for that cycle
//   load_d       : next edge is a frame start (snapshot reload)
//   entry_d      : next edge enters the SHOW phase
//   frame_tick_o : registered frame-start pulse
module hex_scan_timebase
   import hex_scan_pkg::*;
#(
   parameter int SLOT      = 10,
   parameter int DIGITS    = 4,
   parameter int BLANK_CYC = 2,
   localparam int CW       = width_of(SLOT),
   localparam int IW       = width_of(DIGITS)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [IW-1:0] idx_d,
   output phase_t        phase_d,
   output logic          load_d,
   output logic          entry_d,
   output logic          frame_tick_o
);
   logic          run_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q;
   logic          wrap, last;
   assign wrap    = cnt_q == CW'(SLOT - 1);
   assign last    = idx_q == IW'(DIGITS - 1);
   // run_q is clear only until the first edge after reset, which counts as a frame start
   assign cnt_d   = !run_q || wrap ? '0 : cnt_q + CW'(1);
   assign idx_d   = !run_q ? '0 : wrap ? (last ? '0 : idx_q + IW'(1)) : idx_q;
   assign load_d  = !run_q || (wrap && last);
   assign phase_d = cnt_d < CW'(BLANK_CYC) ? BLANK : SHOW;
   assign entry_d = cnt_d == CW'(BLANK_CYC);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         run_q        <= 1'b0;
         cnt_q        <= '0;
         idx_q        <= '0;
         frame_tick_o <= 1'b0;
      end else begin
         run_q        <= 1'b1;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         frame_tick_o <= load_d;
      end
endmodule

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: multiplexed common-anode 7-segment scanner with per-frame snapshot and blanking
//   clk_clk     : system clock
//   reset_reset : asynchronous active-high reset
//   bus         : hex_scan_driver_if slave (hex_in, disp_en, [bright], seg, dig, frame_tick)
// Optional macro HEX_SCAN_DIM_EN adds the bright input and a 4-bit PWM dimmer in SHOW.
module hex_scan_driver
   import hex_scan_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int SCAN_HZ   = 1000,
   parameter int DIGITS    = 4,
   parameter int BLANK_CYC = 500
) (
   input  logic clk_clk,
   input  logic reset_reset,
   hex_scan_driver_if.slave bus
);
   localparam int SLOT = CLK_HZ / SCAN_HZ;
   localparam int IW   = width_of(DIGITS);
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("hex_scan_driver: DIGITS must be 1..8");
   end
   if (BLANK_CYC >= SLOT) begin : g_bad_blank
      $error("hex_scan_driver: BLANK_CYC must be less than SLOT");
   end
   logic [IW-1:0]       idx_d;
   phase_t              phase_d;
   logic                load_d, entry_d, on, lit;
   logic [8*DIGITS-1:0] snap_q, snap_d;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   dig_q, dig_d;
   hex_scan_timebase #(.SLOT(SLOT), .DIGITS(DIGITS), .BLANK_CYC(BLANK_CYC)) u_timebase (
      .clk          (clk_clk),
      .rst          (reset_reset),
      .idx_d        (idx_d),
      .phase_d      (phase_d),
      .load_d       (load_d),
      .entry_d      (entry_d),
      .frame_tick_o (bus.frame_tick)
   );
   assign snap_d = load_d ? bus.hex_in : snap_q;
`ifdef HEX_SCAN_DIM_EN
   logic [3:0] bri_q, bri_d, pwm_q, pwm_d;
   assign bri_d = load_d ? bus.bright : bri_q;
   assign pwm_d = entry_d ? 4'd0 : pwm_q + 4'd1;
   assign on    = pwm_d <= bri_d;
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         bri_q <= 4'hF;
         pwm_q <= 4'd0;
      end else begin
         bri_q <= bri_d;
         pwm_q <= pwm_d;
      end
`else
   wire unused_entry = entry_d;
   assign on = 1'b1;
`endif
   // outputs are computed from next-state timebase values so they line up with the counter
   assign lit   = bus.disp_en && on && phase_d == SHOW;
   assign seg_d = lit ? snap_d[8*idx_d +: 8] : SEG_BLANK;
   assign dig_d = lit ? ~(DIGITS'(1) << idx_d) : '1;
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         snap_q <= '1;
         seg_q  <= SEG_BLANK;
         dig_q  <= '1;
      end else begin
         snap_q <= snap_d;
         seg_q  <= seg_d;
         dig_q  <= dig_d;
      end
   assign bus.seg = seg_q;
   assign bus.dig = dig_q;
endmodule
